// File: rtl/gpsdo_pkg.sv
// gpsdo_pkg: loop state encoding, default loop constants and the duty clamp helper
package gpsdo_pkg;
  typedef enum logic [2:0] {S_ACQ, S_MEAS, S_CALC, S_WAIT, S_HOLD} state_t;
  localparam int unsigned CNT_W = 24;
  localparam int unsigned NOMINAL_D = 10_000_000;
  localparam int unsigned TOL_D = 1_000;
  localparam int unsigned MEAS_TIMEOUT_D = 2_000_000;
  localparam logic [23:0] PHASE_SET_D = 24'd0;
  localparam int unsigned KP_SHIFT_D = 8;
  localparam int unsigned DUTY_INIT_D = 35000;
  localparam int unsigned DUTY_MIN_D = 1000;
  localparam int unsigned DUTY_MAX_D = 64000;
  localparam int unsigned LOCK_THRESH_D = 100;
  localparam int unsigned LOCK_COUNT_D = 8;
  function automatic logic [15:0] clamp_duty(input logic signed [25:0] d, input logic [15:0] lo, input logic [15:0] hi);
    return (d < $signed({10'd0, lo})) ? lo : (d > $signed({10'd0, hi})) ? hi : d[15:0];
  endfunction
endpackage

// File: rtl/pps_period_monitor.sv
// pps_period_monitor: syncs PPS_In, measures edge spacing, flags pps_ok/pps_bad per edge and pps_lost as a level; clr_seen forgets the previous edge
module pps_period_monitor
  import gpsdo_pkg::*;
#(
  parameter int unsigned NOMINAL = NOMINAL_D,
  parameter int unsigned TOL = TOL_D
) (
  input  logic CLK_SYS,
  input  logic CLK_RST,
  input  logic PPS_In,
  input  logic clr_seen,
  output logic pps_ok,
  output logic pps_bad,
  output logic pps_lost
);
  localparam logic [CNT_W-1:0] LO = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] HI = CNT_W'(NOMINAL + TOL);
  logic [2:0] sync;
  logic [CNT_W-1:0] count;
  logic first_seen;
  logic pps_edge;
  always_comb begin
    pps_edge = sync[1] & ~sync[2];
    pps_ok = pps_edge && first_seen && count >= LO && count <= HI;
    pps_bad = pps_edge && first_seen && !pps_ok;
    pps_lost = count > HI;
  end
  always_ff @(posedge CLK_SYS or negedge CLK_RST)
    if (!CLK_RST) begin
      sync <= '0;
      count <= '0;
      first_seen <= 1'b0;
    end else begin
      sync <= {sync[1:0], PPS_In};
      count <= pps_edge ? CNT_W'(1) : count + CNT_W'(!(&count));
      first_seen <= !clr_seen && (first_seen || pps_edge);
    end
endmodule

// File: rtl/gpsdo_loop_ctrl.sv
// gpsdo_loop_ctrl: per-PPS discipline sequencer; CLK_SYS/CLK_RST(async low), PPS_In, Measure_Start/Phase/Done handshake, PWM_Duty, Led_Lock, Holdover
module gpsdo_loop_ctrl
  import gpsdo_pkg::*;
#(
  parameter int unsigned NOMINAL = NOMINAL_D,
  parameter int unsigned TOL = TOL_D,
  parameter int unsigned MEAS_TIMEOUT = MEAS_TIMEOUT_D,
  parameter logic [23:0] PHASE_SET = PHASE_SET_D,
  parameter int unsigned KP_SHIFT = KP_SHIFT_D,
  parameter int unsigned DUTY_INIT = DUTY_INIT_D,
  parameter int unsigned DUTY_MIN = DUTY_MIN_D,
  parameter int unsigned DUTY_MAX = DUTY_MAX_D,
  parameter int unsigned LOCK_THRESH = LOCK_THRESH_D,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_D
) (
  input  logic        CLK_SYS,
  input  logic        CLK_RST,
  input  logic        PPS_In,
  input  logic [23:0] Measure_Phase,
  input  logic        Measure_Done,
  output logic        Measure_Start,
  output logic [15:0] PWM_Duty,
  output logic        Led_Lock,
  output logic        Holdover
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEAS_TIMEOUT);
  localparam logic [7:0] LC = 8'(LOCK_COUNT);
  localparam logic signed [24:0] LT = 25'(LOCK_THRESH);
  localparam logic [15:0] D_INIT = 16'(DUTY_INIT);
  localparam logic [15:0] D_MIN = 16'(DUTY_MIN);
  localparam logic [15:0] D_MAX = 16'(DUTY_MAX);
  state_t state, state_n;
  logic [CNT_W-1:0] tcnt, tcnt_n;
  logic [23:0] phase_q, phase_n;
  logic [7:0] streak, streak_n, streak_c;
  logic [15:0] duty_n;
  logic start_n, lock_n, hold_n;
  logic pps_ok, pps_bad, pps_lost, clr_seen;
  logic signed [24:0] err, step;
  logic signed [25:0] d;
  logic in_lock;
  pps_period_monitor #(.NOMINAL(NOMINAL), .TOL(TOL)) u_mon (
    .CLK_SYS(CLK_SYS),
    .CLK_RST(CLK_RST),
    .PPS_In(PPS_In),
    .clr_seen(clr_seen),
    .pps_ok(pps_ok),
    .pps_bad(pps_bad),
    .pps_lost(pps_lost)
  );
  always_comb begin
    err = $signed({1'b0, phase_q}) - $signed({1'b0, PHASE_SET});
    step = err >>> KP_SHIFT;
    d = $signed({10'd0, PWM_Duty}) - $signed({step[24], step});
    in_lock = err <= LT && err >= -LT;
    streak_c = in_lock ? ((streak == LC) ? LC : streak + 8'd1) : 8'd0;
  end
  always_comb begin
    state_n = state;
    tcnt_n = '0;
    phase_n = phase_q;
    streak_n = streak;
    duty_n = PWM_Duty;
    lock_n = Led_Lock;
    hold_n = Holdover;
    unique case (state)
      S_ACQ: state_n = pps_ok ? S_MEAS : S_ACQ;
      S_MEAS: begin
        tcnt_n = tcnt + CNT_W'(1);
        if (Measure_Done) begin
          phase_n = Measure_Phase;
          state_n = S_CALC;
        end else if (tcnt > TMO) begin
          state_n = S_WAIT;
          streak_n = '0;
          lock_n = 1'b0;
        end
      end
      S_CALC: begin
        duty_n = clamp_duty(d, D_MIN, D_MAX);
        streak_n = streak_c;
        lock_n = streak_c == LC;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (pps_ok) state_n = S_MEAS;
        else if (pps_bad) begin
          streak_n = '0;
          lock_n = 1'b0;
        end else if (pps_lost) begin
          state_n = S_HOLD;
          streak_n = '0;
          lock_n = 1'b0;
          hold_n = 1'b1;
        end
      end
      S_HOLD: begin
        streak_n = '0;
        lock_n = 1'b0;
        if (pps_ok) begin
          state_n = S_MEAS;
          hold_n = 1'b0;
        end
      end
      default: state_n = S_ACQ;
    endcase
    start_n = state_n == S_MEAS && state != S_MEAS;
    // Holdover entry forgets the last edge so recovery needs two good-spaced edges
    clr_seen = state_n == S_HOLD && state != S_HOLD;
  end
  always_ff @(posedge CLK_SYS or negedge CLK_RST)
    if (!CLK_RST) begin
      state <= S_ACQ;
      tcnt <= '0;
      phase_q <= '0;
      streak <= '0;
      Measure_Start <= 1'b0;
      PWM_Duty <= D_INIT;
      Led_Lock <= 1'b0;
      Holdover <= 1'b0;
    end else begin
      state <= state_n;
      tcnt <= tcnt_n;
      phase_q <= phase_n;
      streak <= streak_n;
      Measure_Start <= start_n;
      PWM_Duty <= duty_n;
      Led_Lock <= lock_n;
      Holdover <= hold_n;
    end
endmodule

// File: tb/tb_gpsdo_loop_ctrl.sv
// tb_gpsdo_loop_ctrl: vector table, randomized PPS/phase runs and corner sequences against a behavioural loop model
module tb_gpsdo_loop_ctrl;
  localparam int NOM = 1000, TOL = 10, TMO = 200, KPS = 2, LC = 3, LT = 4;
  localparam int DINIT = 35000, DMIN = 1000, DMAX = 64000;
  logic CLK_SYS = 1'b0, CLK_RST = 1'b0, PPS_In = 1'b0, Measure_Done = 1'b0;
  logic [23:0] Measure_Phase = '0;
  logic Measure_Start, Led_Lock, Holdover;
  logic [15:0] PWM_Duty;
  gpsdo_loop_ctrl #(
    .NOMINAL(NOM), .TOL(TOL), .MEAS_TIMEOUT(TMO), .PHASE_SET(24'd0), .KP_SHIFT(KPS),
    .DUTY_INIT(DINIT), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .LOCK_THRESH(LT), .LOCK_COUNT(LC)
  ) dut (
    .CLK_SYS(CLK_SYS),
    .CLK_RST(CLK_RST),
    .PPS_In(PPS_In),
    .Measure_Phase(Measure_Phase),
    .Measure_Done(Measure_Done),
    .Measure_Start(Measure_Start),
    .PWM_Duty(PWM_Duty),
    .Led_Lock(Led_Lock),
    .Holdover(Holdover)
  );
  always #5 CLK_SYS = ~CLK_SYS;
  typedef struct {int period; int ph; int exp_starts; bit bad;} vec_t;
  vec_t tbl[12];
  int n_chk = 0, n_fail = 0, since_rise = 0;
  int m_duty, m_streak;
  bit m_lock;
  int st, sa;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge CLK_SYS);
    since_rise++;
  endtask
  function automatic void model_reset();
    m_duty = DINIT;
    m_streak = 0;
    m_lock = 1'b0;
  endfunction
  function automatic void model_drop();
    m_streak = 0;
    m_lock = 1'b0;
  endfunction
  function automatic void model_meas(input int ph);
    int err, step, dv, div;
    div = 1 << KPS;
    err = ph;
    step = (err >= 0) ? err / div : -((-err + div - 1) / div);
    dv = m_duty - step;
    m_duty = (dv < DMIN) ? DMIN : (dv > DMAX) ? DMAX : dv;
    m_streak = (err <= LT && err >= -LT) ? ((m_streak < LC) ? m_streak + 1 : LC) : 0;
    m_lock = m_streak == LC;
  endfunction
  task automatic pps_meas(input int period, input int dly, input int ph, input int pend_at, output int starts, output int start_at);
    int done_at, old;
    starts = 0;
    start_at = -1;
    done_at = pend_at;
    old = m_duty;
    while (since_rise < period) tick();
    since_rise = 0;
    for (int i = 0; i < 60; i++) begin
      PPS_In = (i < 5);
      Measure_Phase = 24'(ph);
      Measure_Done = (i == done_at);
      if (i == done_at) begin
        old = m_duty;
        model_meas(ph);
      end
      if (done_at >= 0 && i == done_at + 1) chk("duty_before_update", PWM_Duty, old);
      if (done_at >= 0 && i == done_at + 2) begin
        chk("duty_update", PWM_Duty, m_duty);
        chk("lock_update", Led_Lock, m_lock);
      end
      tick();
      if (Measure_Start) begin
        starts++;
        start_at = i + 1;
        if (dly >= 0 && done_at < 0) done_at = i + 1 + dly;
      end
    end
    Measure_Done = 1'b0;
  endtask
  task automatic lock_up();
    for (int k = 0; k < 3; k++) pps_meas(1000, 20, 2, -1, st, sa);
    chk("lock_up", Led_Lock, 1);
  endtask
  initial begin
    tbl = '{
      '{1000, 0, 0, 1'b0},
      '{1000, 400, 1, 1'b0},
      '{1000, 2, 1, 1'b0},
      '{990, 2, 1, 1'b0},
      '{1010, 2, 1, 1'b0},
      '{1000, 100, 1, 1'b0},
      '{1000, 3, 1, 1'b0},
      '{1000, 4, 1, 1'b0},
      '{1000, 1, 1, 1'b0},
      '{989, 0, 0, 1'b1},
      '{1000, 5, 1, 1'b0},
      '{1000, 16777215, 1, 1'b0}
    };
    model_reset();
    repeat (3) @(negedge CLK_SYS);
    chk("rst_duty", PWM_Duty, DINIT);
    chk("rst_lock", Led_Lock, 0);
    chk("rst_hold", Holdover, 0);
    chk("rst_start", Measure_Start, 0);
    CLK_RST = 1'b1;
    since_rise = 0;
    foreach (tbl[k]) begin
      pps_meas(tbl[k].period, 20, tbl[k].ph, -1, st, sa);
      if (tbl[k].bad) model_drop();
      chk("vec_starts", st, tbl[k].exp_starts);
      if (tbl[k].exp_starts == 1) chk("vec_start_latency", sa, 3);
      chk("vec_duty", PWM_Duty, m_duty);
      chk("vec_lock", Led_Lock, m_lock);
      chk("vec_hold", Holdover, 0);
    end
    for (int k = 0; k < 12; k++) begin
      int per, ph;
      per = int'($urandom_range(990, 1010));
      ph = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 60000));
      pps_meas(per, int'($urandom_range(5, 30)), ph, -1, st, sa);
      chk("rnd_starts", st, 1);
      chk("rnd_duty", PWM_Duty, m_duty);
      chk("rnd_lock", Led_Lock, m_lock);
    end
    lock_up();
    pps_meas(1000, -1, 0, -1, st, sa);
    chk("tmo_starts", st, 1);
    while (since_rise < 190) tick();
    chk("tmo_lock_held", Led_Lock, 1);
    while (since_rise < 240) tick();
    model_drop();
    chk("tmo_lock_drop", Led_Lock, 0);
    chk("tmo_duty", PWM_Duty, m_duty);
    Measure_Phase = 24'd40000;
    Measure_Done = 1'b1;
    tick();
    Measure_Done = 1'b0;
    repeat (3) tick();
    chk("late_done_ignored", PWM_Duty, m_duty);
    pps_meas(1000, 20, 3, -1, st, sa);
    chk("tmo_recover_starts", st, 1);
    chk("tmo_recover_latency", sa, 3);
    lock_up();
    while (since_rise < 1005) tick();
    chk("hold_not_yet", Holdover, 0);
    while (since_rise < 1020) tick();
    model_drop();
    chk("hold_set", Holdover, 1);
    chk("hold_lock", Led_Lock, 0);
    chk("hold_duty", PWM_Duty, m_duty);
    pps_meas(3000, 20, 5, -1, st, sa);
    chk("hold_first_edge_starts", st, 0);
    chk("hold_still", Holdover, 1);
    pps_meas(1000, 20, 5, -1, st, sa);
    chk("hold_exit_starts", st, 1);
    chk("hold_exit", Holdover, 0);
    chk("hold_exit_duty", PWM_Duty, m_duty);
    lock_up();
    pps_meas(1050, 20, 2, -1, st, sa);
    model_drop();
    chk("late_pps_starts", st, 0);
    chk("late_pps_lock", Led_Lock, 0);
    chk("late_pps_hold", Holdover, 1);
    pps_meas(1000, 20, 2, -1, st, sa);
    chk("late_pps_recover", st, 1);
    chk("late_pps_hold_clr", Holdover, 0);
    pps_meas(1000, -1, 0, -1, st, sa);
    chk("coin_arm", st, 1);
    pps_meas(100, -1, 80, 2, st, sa);
    chk("coin_no_start", st, 0);
    chk("coin_duty", PWM_Duty, m_duty);
    pps_meas(1000, 20, 4, -1, st, sa);
    chk("coin_next_starts", st, 1);
    chk("coin_next_hold", Holdover, 0);
    pps_meas(1000, -1, 0, -1, st, sa);
    chk("rst_arm", st, 1);
    #2 CLK_RST = 1'b0;
    #1;
    model_reset();
    chk("arst_duty", PWM_Duty, m_duty);
    chk("arst_lock", Led_Lock, 0);
    chk("arst_hold", Holdover, 0);
    chk("arst_start", Measure_Start, 0);
    repeat (2) tick();
    CLK_RST = 1'b1;
    Measure_Phase = 24'd400;
    Measure_Done = 1'b1;
    tick();
    Measure_Done = 1'b0;
    repeat (3) tick();
    chk("rst_done_ignored", PWM_Duty, DINIT);
    pps_meas(1000, 20, 400, -1, st, sa);
    chk("rst_first_edge", st, 0);
    pps_meas(1000, 20, 400, -1, st, sa);
    chk("rst_second_edge", st, 1);
    chk("rst_duty_step", PWM_Duty, 34900);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
